// File: rtl/perf_event_collector.sv
// Performance-counter bank: counts per-event pulses, then freezes on halt and streams all counters out in index order.
// Build option: define PERF_SATURATE_EN to make counters saturate instead of wrapping.
module perf_event_collector #(
    parameter int NUM_EVENTS = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int IDX_WIDTH  = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  halt_i,
    input  logic                  clear_i,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [IDX_WIDTH-1:0]  dump_idx_o,
    output logic [CNT_WIDTH-1:0]  dump_data_o,
    output logic                  dump_last_o,
    output logic                  done_o,
    output logic [NUM_EVENTS-1:0] ovf_o,
    output logic [1:0]            dbg_state
);

    // Dump handshake: a word moves on any rising edge where dump_valid_o && dump_ready_i;
    // while valid is high and ready is low, idx/data/valid hold steady.
    typedef enum logic [1:0] {
        S_COUNT = 2'd0,
        S_DRAIN = 2'd1,
        S_DUMP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_EVENTS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt     [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] cnt_inc [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_hit;

    // An event arriving at an all-ones counter is the overflow condition in both modes.
    always_comb begin
        for (int k = 0; k < NUM_EVENTS; k++) begin
            ovf_hit[k] = event_i[k] && (cnt[k] == CNT_MAX);
`ifdef PERF_SATURATE_EN
            cnt_inc[k] = ovf_hit[k] ? cnt[k] : cnt[k] + CNT_WIDTH'(event_i[k]);
`else
            cnt_inc[k] = cnt[k] + CNT_WIDTH'(event_i[k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_EVENTS; k++) cnt[k] <= '0;
            ovf_o        <= '0;
            dump_valid_o <= 1'b0;
            dump_idx_o   <= '0;
            dump_data_o  <= '0;
            done_o       <= 1'b0;
            state        <= S_COUNT;
        end else begin
            case (state)
                S_COUNT: begin
                    // Halt wins over clear; the halt-cycle events still count.
                    if (halt_i || !clear_i) begin
                        for (int k = 0; k < NUM_EVENTS; k++) cnt[k] <= cnt_inc[k];
                        ovf_o <= ovf_o | ovf_hit;
                    end else begin
                        for (int k = 0; k < NUM_EVENTS; k++) cnt[k] <= '0;
                        ovf_o <= '0;
                    end
                    if (halt_i) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    dump_data_o  <= cnt[0];
                    dump_idx_o   <= '0;
                    dump_valid_o <= 1'b1;
                    state        <= S_DUMP;
                end
                S_DUMP: begin
                    if (dump_ready_i) begin
                        if (dump_idx_o == LAST_IDX) begin
                            dump_valid_o <= 1'b0;
                            done_o       <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            dump_idx_o  <= dump_idx_o + 1'b1;
                            dump_data_o <= cnt[dump_idx_o + 1'b1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dump_last_o = dump_valid_o && (dump_idx_o == LAST_IDX);
    assign dbg_state   = state;

endmodule

// File: tb/tb_perf_event_collector.sv
// Scoreboard bench for perf_event_collector: default-size DUT plus a CNT_WIDTH=4 instance for overflow.
module tb_perf_event_collector;

    localparam int N  = 16;
    localparam int W  = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, halt_i, clear_i, dump_ready_i;
    logic [N-1:0]  event_i;
    logic          dump_valid_o, dump_last_o, done_o;
    logic [3:0]    dump_idx_o;
    logic [W-1:0]  dump_data_o;
    logic [N-1:0]  ovf_o;
    logic [1:0]    dbg_state;

    logic          s_rst, s_halt, s_clear, s_ready;
    logic [N-1:0]  s_event;
    logic          s_valid, s_last, s_done;
    logic [3:0]    s_idx;
    logic [SW-1:0] s_data;
    logic [N-1:0]  s_ovf;
    logic [1:0]    s_state;

    perf_event_collector #(.NUM_EVENTS(N), .CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .event_i(event_i), .halt_i(halt_i), .clear_i(clear_i),
        .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_idx_o(dump_idx_o),
        .dump_data_o(dump_data_o), .dump_last_o(dump_last_o), .done_o(done_o),
        .ovf_o(ovf_o), .dbg_state(dbg_state)
    );

    perf_event_collector #(.NUM_EVENTS(N), .CNT_WIDTH(SW)) dut_small (
        .clk(clk), .rst(s_rst), .event_i(s_event), .halt_i(s_halt), .clear_i(s_clear),
        .dump_valid_o(s_valid), .dump_ready_i(s_ready), .dump_idx_o(s_idx),
        .dump_data_o(s_data), .dump_last_o(s_last), .done_o(s_done),
        .ovf_o(s_ovf), .dbg_state(s_state)
    );

    int tests = 0;
    int fails = 0;
    int hs_count = 0;
    int s_hs_count = 0;

    logic [W+4:0]  exp_q[$];     // {last, idx, data}
    logic [SW+4:0] s_exp_q[$];
    logic [W-1:0]  model[N];
    bit            model_halted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    logic         stall_q = 1'b0;
    logic [3:0]   stall_idx;
    logic [W-1:0] stall_data;

    always @(negedge clk) begin
        logic [W+4:0] e;
        if (rst) begin
            if (stall_q) begin
                check("hold_valid", 64'(dump_valid_o), 64'd1);
                check("hold_idx", 64'(dump_idx_o), 64'(stall_idx));
                check("hold_data", 64'(dump_data_o), 64'(stall_data));
            end
            if (dump_valid_o && dump_ready_i) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: idx %0d data %0h with empty queue", dump_idx_o, dump_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("word_idx", 64'(dump_idx_o), 64'(e[W+3:W]));
                    check("word_data", 64'(dump_data_o), 64'(e[W-1:0]));
                    check("word_last", 64'(dump_last_o), 64'(e[W+4]));
                end
            end
            stall_q    = dump_valid_o && !dump_ready_i;
            stall_idx  = dump_idx_o;
            stall_data = dump_data_o;
        end else begin
            stall_q = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [SW+4:0] e;
        if (s_rst && s_valid && s_ready) begin
            s_hs_count++;
            if (s_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL small_unexpected_word: idx %0d data %0h", s_idx, s_data);
            end else begin
                e = s_exp_q.pop_front();
                check("small_idx", 64'(s_idx), 64'(e[SW+3:SW]));
                check("small_data", 64'(s_data), 64'(e[SW-1:0]));
                check("small_last", 64'(s_last), 64'(e[SW+4]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b0; event_i = '0; halt_i = 1'b0; clear_i = 1'b0; dump_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_valid", 64'(dump_valid_o), 64'd0);
        check("rst_idx", 64'(dump_idx_o), 64'd0);
        check("rst_data", 64'(dump_data_o), 64'd0);
        check("rst_last", 64'(dump_last_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        for (int k = 0; k < N; k++) model[k] = '0;
        model_halted = 1'b0;
        exp_q.delete();
        rst = 1'b1;
    endtask

    // One COUNT-phase cycle; the model follows the counting rules and queues the dump on halt.
    task automatic cycle(input logic [N-1:0] ev, input logic clr, input logic hlt);
        event_i = ev; clear_i = clr; halt_i = hlt;
        @(posedge clk); #1;
        event_i = '0; clear_i = 1'b0; halt_i = 1'b0;
        if (!model_halted) begin
            if (hlt || !clr) begin
                for (int k = 0; k < N; k++) model[k] = model[k] + W'(ev[k]);
            end else begin
                for (int k = 0; k < N; k++) model[k] = '0;
            end
            if (hlt) begin
                model_halted = 1'b1;
                for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), 4'(k), model[k]});
            end
        end
    endtask

    task automatic wait_done(input bit toggle, input bit check_len);
        int first_v = -1;
        int done_c  = -1;
        hs_count = 0;
        check("drain_valid", 64'(dump_valid_o), 64'd0);
        check("drain_state", 64'(dbg_state), 64'd1);
        for (int c = 1; c <= 200; c++) begin
            dump_ready_i = toggle ? ((c % 4) == 1 || (c % 4) == 0) : 1'b1;
            event_i = 16'hFFFF;   // must be ignored once draining
            @(posedge clk); #1;
            if (dump_valid_o && first_v < 0) first_v = c;
            if (done_o) begin
                done_c = c;
                break;
            end
        end
        dump_ready_i = 1'b0;
        event_i = '0;
        if (done_c < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: done_o never rose, handshakes %0d", hs_count);
        end else begin
            check("first_valid_latency", 64'(first_v), 64'd1);
            if (check_len) check("dump_length", 64'(done_c - first_v), 64'd16);
            check("handshakes", 64'(hs_count), 64'd16);
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("done_valid", 64'(dump_valid_o), 64'd0);
            check("done_last", 64'(dump_last_o), 64'd0);
            check("done_state", 64'(dbg_state), 64'd3);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0; event_i = '0; halt_i = 1'b0; clear_i = 1'b0; dump_ready_i = 1'b0;
        s_rst = 1'b0; s_event = '0; s_halt = 1'b0; s_clear = 1'b0; s_ready = 1'b0;

        // bit 0 ten times, halt pulse
        do_reset();
        for (int i = 0; i < 10; i++) cycle(16'h0001, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        wait_done(1'b0, 1'b1);

        // all bits five cycles, halt in the fifth
        do_reset();
        for (int i = 0; i < 4; i++) cycle(16'hFFFF, 1'b0, 1'b0);
        cycle(16'hFFFF, 1'b0, 1'b1);
        wait_done(1'b0, 1'b1);
        check("ovf_none", 64'(ovf_o), 64'd0);

        // clear discards its own cycle's events
        do_reset();
        for (int i = 0; i < 7; i++) cycle(16'h0008, 1'b0, 1'b0);
        cycle(16'h0008, 1'b1, 1'b0);
        cycle(16'h0008, 1'b0, 1'b0);
        cycle(16'h0008, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        wait_done(1'b0, 1'b1);

        // halt beats clear in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) cycle(16'h0008, 1'b0, 1'b0);
        cycle(16'h0008, 1'b1, 1'b1);
        wait_done(1'b0, 1'b1);

        // mixed patterns, ready toggling 1,0,0,1
        do_reset();
        cycle(16'hA5A5, 1'b0, 1'b0);
        cycle(16'h00FF, 1'b0, 1'b0);
        cycle(16'h00FF, 1'b0, 1'b0);
        cycle(16'h1234, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        wait_done(1'b1, 1'b0);

        // DONE is terminal
        cycle(16'hFFFF, 1'b1, 1'b1);
        cycle(16'hFFFF, 1'b0, 1'b1);
        check("done_sticky", 64'(done_o), 64'd1);
        check("done_no_valid", 64'(dump_valid_o), 64'd0);
        check("done_state_hold", 64'(dbg_state), 64'd3);

        // reset in the middle of a dump
        do_reset();
        for (int i = 0; i < 3; i++) cycle(16'hFFFF, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 100; c++) begin
                dump_ready_i = 1'b1;
                @(posedge clk); #1;
                if (dump_valid_o && dump_idx_o == 4'd6) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) begin
                tests++;
                fails++;
                $display("FAIL reach_idx6: idx %0d valid %0b", dump_idx_o, dump_valid_o);
            end
        end
        dump_ready_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", 64'(dump_valid_o), 64'd0);
        check("abort_done", 64'(done_o), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        check("abort_remaining", 64'(exp_q.size()), 64'd10);
        exp_q.delete();
        for (int k = 0; k < N; k++) model[k] = '0;
        model_halted = 1'b0;
        rst = 1'b1;
        cycle(16'h0000, 1'b0, 1'b1);
        wait_done(1'b0, 1'b1);

        // 4-bit counters: 17 events on bit 0
        @(posedge clk); #1;
        s_rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_event = 16'h0001;
            @(posedge clk); #1;
        end
        s_event = '0;
        s_halt = 1'b1;
        @(posedge clk); #1;
        s_halt = 1'b0;
        for (int k = 0; k < N; k++) begin
`ifdef PERF_SATURATE_EN
            s_exp_q.push_back({(k == N - 1), 4'(k), (k == 0) ? 4'd15 : 4'd0});
`else
            s_exp_q.push_back({(k == N - 1), 4'(k), (k == 0) ? 4'd1 : 4'd0});
`endif
        end
        check("small_ovf", 64'(s_ovf), 64'h0001);
        s_ready = 1'b1;
        for (int c = 0; c < 100 && !s_done; c++) begin
            @(posedge clk); #1;
        end
        s_ready = 1'b0;
        check("small_done", 64'(s_done), 64'd1);
        check("small_handshakes", 64'(s_hs_count), 64'd16);
        check("small_queue_empty", 64'(s_exp_q.size()), 64'd0);
        check("small_ovf_after", 64'(s_ovf), 64'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
